// File: rtl/iob_regfile_bist.sv
// Built-in self test for a small register file: writes an incrementing pattern,
// reads it back, clears the file and checks that every location reads zero.
module iob_regfile_bist #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int SEQ_INI = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rf_rst,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_w_data,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CLEAR, ZERO, FIN} state_t;

    localparam logic [DATA_W-1:0] SEQ_BASE = DATA_W'(SEQ_INI);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rf_rst_q, rf_rst_d;
    logic                rf_we_q, rf_we_d;
    logic [DATA_W-1:0]   rf_w_data_q, rf_w_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [DATA_W-1:0]   err_data_q, err_data_d;

    logic                cnt_last;
    logic [DATA_W-1:0]   exp_data;

    assign cnt_last = (cnt_q == '1);
    assign exp_data = SEQ_BASE + DATA_W'(cnt_q);

    // NOTE: every variable gets a default at the top of the block so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_addr_d = err_addr_q;
        err_data_d = err_data_q;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d    = WRITE;
                    cnt_d      = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_addr_d = '0;
                    err_data_d = '0;
                end
            end
            WRITE: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_last) state_d = READ;
            end
            READ: begin
                if (rf_r_data != exp_data) begin
                    state_d    = FIN;
                    done_d     = 1'b1;
                    err_addr_d = cnt_q;
                    err_data_d = rf_r_data;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_last) state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
            ZERO: begin
                if (rf_r_data != '0) begin
                    state_d    = FIN;
                    done_d     = 1'b1;
                    err_addr_d = cnt_q;
                    err_data_d = rf_r_data;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_last) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered yet
        // line up with the state and address they belong to.
        rf_we_d     = (state_d == WRITE);
        rf_rst_d    = (state_d == CLEAR);
        busy_d      = (state_d inside {WRITE, READ, CLEAR, ZERO});
        rf_w_data_d = rf_we_d ? (SEQ_BASE + DATA_W'(cnt_d)) : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rf_rst_q    <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_w_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rf_rst_q    <= rf_rst_d;
            rf_we_q     <= rf_we_d;
            rf_w_data_q <= rf_w_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
        end
    end

    assign rf_rst    = rf_rst_q;
    assign rf_we     = rf_we_q;
    assign rf_addr   = cnt_q;
    assign rf_w_data = rf_w_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;

endmodule
